// File: rtl/stat_counter_pkg.sv
// -----------------------------------------------------------------------------
// stat_pkg
// Shared definitions for the retirement statistics block:
//   - instruction class encodings as presented on instr_class
//   - record ids, i.e. the order in which counters are dumped
//   - NUM_REC, the default number of dumped records
//   - the three controller states
// -----------------------------------------------------------------------------
package stat_pkg;

  // Encoding of instr_class for a retiring instruction.
  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_ITYPE   = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_SYSCALL = 3'd6,
    CLS_OTHER   = 3'd7
  } instr_class_e;

  // Record ids, in dump order.
  localparam logic [3:0] REC_CYCLES  = 4'd0;
  localparam logic [3:0] REC_INSTR   = 4'd1;
  localparam logic [3:0] REC_RTYPE   = 4'd2;
  localparam logic [3:0] REC_ITYPE   = 4'd3;
  localparam logic [3:0] REC_LOAD    = 4'd4;
  localparam logic [3:0] REC_STORE   = 4'd5;
  localparam logic [3:0] REC_BRANCH  = 4'd6;
  localparam logic [3:0] REC_TAKEN   = 4'd7;
  localparam logic [3:0] REC_JUMP    = 4'd8;
  localparam logic [3:0] REC_SYSCALL = 4'd9;

  localparam int NUM_REC = 10;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_COUNT = 2'd0;
  localparam state_t ST_DUMP  = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/stat_counter_if.sv
// -----------------------------------------------------------------------------
// stat_counter_if
// Bundles the retirement inputs and the record dump handshake of stat_counter.
//   instr_valid/instr_class/branch_taken : one retiring instruction per cycle
//   run_stats                            : level terminate request
//   rec_valid/rec_ready/rec_id/rec_data  : record dump handshake
//   done                                 : every record has been accepted
// Modports: slave = stat_counter side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface stat_counter_if #(
  parameter int CNT_W = 32
);

  logic             instr_valid;
  logic [2:0]       instr_class;
  logic             branch_taken;
  logic             run_stats;
  logic             rec_valid;
  logic             rec_ready;
  logic [3:0]       rec_id;
  logic [CNT_W-1:0] rec_data;
  logic             done;

  modport slave (
    input  instr_valid, instr_class, branch_taken, run_stats, rec_ready,
    output rec_valid, rec_id, rec_data, done
  );

  modport master (
    output instr_valid, instr_class, branch_taken, run_stats, rec_ready,
    input  rec_valid, rec_id, rec_data, done
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// CNT_W-wide up counter that sticks at all-ones instead of wrapping.
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low clear
//   inc   : increment enable
//   count : current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stat_counter.sv
// -----------------------------------------------------------------------------
// stat_counter
// Counts cycles and retired instructions by class until run_stats is seen,
// then dumps the frozen counters one record per accepted handshake and parks
// in a done state until reset.
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : stat_counter_if.slave (retirement inputs, record handshake, done)
// Parameters:
//   CNT_W   : counter and rec_data width
//   NUM_REC : number of dumped records, ids 0..NUM_REC-1 (at most 16)
// -----------------------------------------------------------------------------
module stat_counter #(
  parameter int CNT_W   = 32,
  parameter int NUM_REC = stat_pkg::NUM_REC
) (
  input  logic          clk,
  input  logic          rst_n,
  stat_counter_if.slave bus
);

  import stat_pkg::*;

  localparam logic [3:0] LAST_ID = 4'(NUM_REC - 1);

  state_t           state;
  logic [3:0]       rec_id;
  logic [15:0]      inc_map;
  logic [CNT_W-1:0] cnt [NUM_REC];
  logic [CNT_W-1:0] rec_data;

  // ---------------------------------------------------------------------------
  // Increment enables, one bit per record id. Everything is gated by COUNT,
  // which is what freezes the counters during the dump.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    inc_map = '0;
    if (state == ST_COUNT) begin
      inc_map[REC_CYCLES] = 1'b1;
      if (bus.instr_valid) begin
        inc_map[REC_INSTR] = 1'b1;
        unique case (bus.instr_class)
          CLS_RTYPE:   inc_map[REC_RTYPE]   = 1'b1;
          CLS_ITYPE:   inc_map[REC_ITYPE]   = 1'b1;
          CLS_LOAD:    inc_map[REC_LOAD]    = 1'b1;
          CLS_STORE:   inc_map[REC_STORE]   = 1'b1;
          CLS_BRANCH: begin
            inc_map[REC_BRANCH] = 1'b1;
            inc_map[REC_TAKEN]  = bus.branch_taken;
          end
          CLS_JUMP:    inc_map[REC_JUMP]    = 1'b1;
          CLS_SYSCALL: inc_map[REC_SYSCALL] = 1'b1;
          CLS_OTHER:   ;  // only the instruction total
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_REC; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_map[g]),
      .count (cnt[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Controller. run_stats is only looked at in COUNT and rec_ready only in
  // DUMP, so a dropped run_stats cannot abort a dump in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_COUNT;
      rec_id <= '0;
    end else begin
      unique case (state)
        ST_COUNT: begin
          if (bus.run_stats) begin
            state  <= ST_DUMP;
            rec_id <= '0;
          end
        end
        ST_DUMP: begin
          if (bus.rec_ready) begin
            if (rec_id == LAST_ID) begin
              state <= ST_DONE;
            end else begin
              rec_id <= rec_id + 1'b1;
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_COUNT;
      endcase
    end
  end

  // Zero-latency record select on rec_id.
  always_comb begin
    rec_data = '0;
    for (int i = 0; i < NUM_REC; i++) begin
      if (rec_id == 4'(i)) begin
        rec_data = cnt[i];
      end
    end
  end

  assign bus.rec_valid = (state == ST_DUMP);
  assign bus.done      = (state == ST_DONE);
  assign bus.rec_id    = rec_id;
  assign bus.rec_data  = rec_data;

endmodule

// File: tb/tb_stat_counter.sv
// -----------------------------------------------------------------------------
// tb_stat_counter
// Directed stimulus with hand-computed records pushed into a queue per DUT;
// a monitor per DUT pops and compares on every accepted record. A second
// instance with CNT_W=4 exercises saturation.
// -----------------------------------------------------------------------------
module tb_stat_counter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stat_counter_if #(.CNT_W(32)) bus  ();
  stat_counter_if #(.CNT_W(4))  bus4 ();

  stat_counter #(.CNT_W(32), .NUM_REC(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  stat_counter #(.CNT_W(4), .NUM_REC(10)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
  } rec_t;

  rec_t        q  [$];
  rec_t        q4 [$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          last_pop  = 0;
  int          last_pop4 = 0;
  logic [31:0] exp_v [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every accepted record must match the queue head.
  always @(negedge clk) begin
    if (bus.rec_valid && bus.rec_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_record: got id %0d expected none", bus.rec_id);
      end else begin
        rec_t e;
        e = q.pop_front();
        check($sformatf("rec%0d_id", e.id), 32'(bus.rec_id), 32'(e.id));
        check($sformatf("rec%0d_data", e.id), bus.rec_data, e.data);
        last_pop = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (bus4.rec_valid && bus4.rec_ready) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_record4: got id %0d expected none", bus4.rec_id);
      end else begin
        rec_t e;
        e = q4.pop_front();
        check($sformatf("w4_rec%0d_id", e.id), 32'(bus4.rec_id), 32'(e.id));
        check($sformatf("w4_rec%0d_data", e.id), 32'(bus4.rec_data), e.data);
        last_pop4 = cyc;
      end
    end
  end

  task automatic push_run(input logic [31:0] v [10], input int n, input bit narrow);
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r.id   = 4'(i);
      r.data = v[i];
      if (narrow) q4.push_back(r);
      else        q.push_back(r);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves rst_n low just after a rising edge; the caller releases it together
  // with its first stimulus so the next edge is the first counting edge.
  task automatic do_reset(input string tag);
    rst_n             = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr_class   = 3'd0;
    bus.branch_taken  = 1'b0;
    bus.run_stats     = 1'b0;
    bus.rec_ready     = 1'b0;
    bus4.instr_valid  = 1'b0;
    bus4.instr_class  = 3'd0;
    bus4.branch_taken = 1'b0;
    bus4.run_stats    = 1'b0;
    bus4.rec_ready    = 1'b0;
    step();
    step();
    check({tag, "_rst_valid"}, 32'(bus.rec_valid), 0);
    check({tag, "_rst_done"},  32'(bus.done), 0);
    check({tag, "_rst_id"},    32'(bus.rec_id), 0);
  endtask

  // Bounded wait for done; optionally wiggles the ignored inputs meanwhile.
  task automatic wait_done(input string tag, input bit wiggle);
    int i = 0;
    while (!bus.done && i < 60) begin
      @(negedge clk);
      if (wiggle) begin
        bus.instr_valid  = ~bus.instr_valid;
        bus.branch_taken = ~bus.branch_taken;
      end
      i++;
    end
    check({tag, "_done"},      32'(bus.done), 1);
    check({tag, "_valid_off"}, 32'(bus.rec_valid), 0);
    check({tag, "_all_recs"},  32'(q.size()), 0);
    check({tag, "_done_lat"},  32'(cyc - last_pop), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 5 R-type, then syscall retiring with run_stats ----
    do_reset("t1");
    exp_v = '{6, 6, 5, 0, 0, 0, 0, 0, 0, 1};
    push_run(exp_v, 10, 1'b0);
    rst_n           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_class = 3'd0;
    bus.rec_ready   = 1'b1;   // must be ignored while counting
    repeat (5) step();
    bus.instr_class = 3'd6;
    bus.run_stats   = 1'b1;
    step();
    bus.run_stats   = 1'b0;   // dropping the request must not abort the dump
    wait_done("t1", 1'b1);
    // DONE must hold through wiggled inputs and a fresh run_stats pulse.
    for (int k = 0; k < 6; k++) begin
      bus.instr_valid = ~bus.instr_valid;
      bus.run_stats   = k[0];
      @(negedge clk);
      check($sformatf("t1_hold_done%0d", k),  32'(bus.done), 1);
      check($sformatf("t1_hold_valid%0d", k), 32'(bus.rec_valid), 0);
      step();
    end

    // ---- branches taken 1,0,1 plus a taken flag on an R-type; stall at id 2 ----
    do_reset("t2");
    exp_v = '{5, 4, 1, 0, 0, 0, 3, 2, 0, 0};
    push_run(exp_v, 10, 1'b0);
    rst_n            = 1'b1;
    bus.instr_valid  = 1'b1;
    bus.instr_class  = 3'd4;
    bus.branch_taken = 1'b1;
    bus.rec_ready    = 1'b1;
    step();
    bus.branch_taken = 1'b0;
    step();
    bus.branch_taken = 1'b1;
    step();
    bus.instr_class  = 3'd0;
    step();
    bus.instr_valid  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.run_stats    = 1'b1;
    step();                   // enter DUMP at id 0
    bus.run_stats    = 1'b0;
    step();                   // id 0 accepted
    step();                   // id 1 accepted
    bus.rec_ready    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t2_stall_id%0d", k),    32'(bus.rec_id), 2);
      check($sformatf("t2_stall_data%0d", k),  bus.rec_data, 1);
      check($sformatf("t2_stall_valid%0d", k), 32'(bus.rec_valid), 1);
      step();
    end
    bus.rec_ready = 1'b1;
    wait_done("t2", 1'b0);

    // ---- reset in the middle of a dump, then a fresh run ----
    do_reset("t3a");
    exp_v = '{4, 4, 0, 0, 3, 1, 0, 0, 0, 0};
    push_run(exp_v, 5, 1'b0);
    rst_n           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_class = 3'd2;
    bus.rec_ready   = 1'b1;
    repeat (3) step();
    bus.instr_class = 3'd3;
    bus.run_stats   = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.run_stats   = 1'b0;
    repeat (5) step();        // ids 0..4 accepted
    bus.rec_ready   = 1'b0;
    @(negedge clk);
    check("t3_pre_id",    32'(bus.rec_id), 5);
    check("t3_pre_valid", 32'(bus.rec_valid), 1);
    check("t3_pre_data",  bus.rec_data, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t3_async_valid", 32'(bus.rec_valid), 0);
    check("t3_async_id",    32'(bus.rec_id), 0);
    check("t3_async_done",  32'(bus.done), 0);
    check("t3_partial",     32'(q.size()), 0);
    do_reset("t3b");
    exp_v = '{3, 3, 0, 1, 0, 0, 0, 0, 2, 0};
    push_run(exp_v, 10, 1'b0);
    rst_n            = 1'b1;
    bus.instr_valid  = 1'b1;
    bus.instr_class  = 3'd5;
    bus.rec_ready    = 1'b1;
    repeat (2) step();
    bus.instr_class  = 3'd1;
    bus.branch_taken = 1'b1;  // not a branch, so not a taken branch
    bus.run_stats    = 1'b1;
    step();
    bus.instr_valid  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.run_stats    = 1'b0;
    wait_done("t3b", 1'b1);

    // ---- 4-bit counters saturate ----
    do_reset("t4");
    exp_v = '{15, 15, 15, 0, 0, 0, 0, 0, 0, 0};
    push_run(exp_v, 10, 1'b1);
    rst_n            = 1'b1;
    bus4.instr_valid = 1'b1;
    bus4.instr_class = 3'd0;
    bus4.rec_ready   = 1'b1;
    repeat (20) step();
    bus4.instr_valid = 1'b0;
    bus4.run_stats   = 1'b1;
    step();
    bus4.run_stats   = 1'b0;
    for (int i = 0; i < 60 && !bus4.done; i++) @(negedge clk);
    check("t4_done",     32'(bus4.done), 1);
    check("t4_all_recs", 32'(q4.size()), 0);
    check("t4_done_lat", 32'(cyc - last_pop4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stat_counter.md
STAT_COUNTER -- requirements
Module: stat_counter

Interface
REQ-001 Parameter CNT_W, default 32, SHALL set the counter width and the rec_data width.
REQ-002 Parameter NUM_REC, default 10, SHALL set the number of dumped records, ids 0..NUM_REC-1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 instr_valid  input  1  SHALL mean one instruction retires this cycle.
REQ-006 instr_class  input  3  SHALL encode the retiring instruction: 0 R-type, 1 I-type ALU, 2 load, 3 store, 4 branch, 5 jump, 6 syscall, 7 other.
REQ-007 branch_taken  input  1  SHALL mean the retiring branch was taken; valid only with class 4.
REQ-008 run_stats  input  1  SHALL be the level terminate request from the syscall block (syscall 10).
REQ-009 rec_valid  output  1  SHALL mean rec_id/rec_data hold a record.
REQ-010 rec_ready  input  1  SHALL mean the consumer accepts the record this cycle.
REQ-011 rec_id  output  4  SHALL give the record index.
REQ-012 rec_data  output  CNT_W  SHALL give the counter value for rec_id.
REQ-013 done  output  1  SHALL mean all records were accepted.

Function
REQ-014 States SHALL be COUNT, DUMP and DONE.
REQ-015 Record map SHALL be: 0 cycles, 1 instructions, 2 R-type, 3 I-type, 4 load, 5 store, 6 branch, 7 branch taken, 8 jump, 9 syscall.
REQ-016 In COUNT, the cycle counter SHALL increment on every clock edge, including the edge on which run_stats is first sampled high.
REQ-017 In COUNT, when instr_valid=1, the instruction counter and the counter for instr_class SHALL each increment by 1; class 7 SHALL increment only the instruction counter.
REQ-018 The branch-taken counter SHALL increment only when instr_valid=1, instr_class=4 and branch_taken=1.
REQ-019 Every counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 In COUNT with run_stats=1, the retirement in that same cycle SHALL be counted, the state SHALL move to DUMP, and rec_id SHALL be 0.
REQ-021 In DUMP and DONE, all counters SHALL be frozen, and instr_valid and branch_taken SHALL be ignored.
REQ-022 In DUMP, rec_valid SHALL be 1 and rec_data SHALL equal the frozen counter selected by rec_id, with zero latency from rec_id.
REQ-023 In DUMP, rec_id and rec_data SHALL stay stable while rec_ready=0.
REQ-024 On rec_valid and rec_ready, rec_id SHALL advance by 1.
REQ-025 Acceptance of id NUM_REC-1 SHALL move the state to DONE.
REQ-026 In DONE, done SHALL be 1 and rec_valid SHALL be 0, until reset.
REQ-027 run_stats SHALL be ignored in DUMP and DONE; a deassertion of run_stats SHALL NOT abort the dump.
REQ-028 rec_ready SHALL be ignored outside DUMP.

Reset
REQ-029 On rst_n=0, the block SHALL immediately enter COUNT, clear all counters, and drive rec_id=0, rec_valid=0, done=0.
REQ-030 A reset during DUMP SHALL discard the remaining records; counting SHALL restart from zero after reset is released.
REQ-031 The first counting edge SHALL be the first rising clk edge with rst_n=1.

Structure
REQ-032 Package stat_pkg SHALL hold the class encodings, the record-id constants, NUM_REC and the state enumeration.
REQ-033 Sub-module sat_counter SHALL be a CNT_W-wide saturating counter with async active-low clear and an increment enable; stat_counter SHALL instantiate it once per record.
REQ-034 Record selection SHALL be a combinational multiplexer on rec_id.

Verification
REQ-035 Bench: reset, 5 cycles with class 0 retiring, run_stats high on cycle 6 with class 6 retiring, rec_ready=1 -> records 0..9 = 6,6,5,0,0,0,0,0,0,1; done on the cycle after id 9 is accepted.
REQ-036 Bench: 3 branches with branch_taken=1,0,1 -> record 6 = 3, record 7 = 2; branch_taken with class 0 SHALL NOT count.
REQ-037 Bench: rec_ready=0 for 4 cycles at rec_id=2 -> rec_id and rec_data SHALL be unchanged, with no skipped or duplicated id once ready returns.
REQ-038 Bench: CNT_W=4 with 20 R-type retirements -> record 2 = 15 and record 1 = 15.
REQ-039 Bench: rst_n pulsed low at rec_id=5 -> rec_valid=0 at once; after release, a new run yields fresh counts starting from 0.
REQ-040 Bench: instr_valid toggling during DUMP and DONE, and run_stats re-pulsed in DONE -> record values and done SHALL be unchanged.
